// File: rtl/logical_tile_io_bank_cfg_pkg.sv
// Shared definitions for the embedded IO bank: per-channel mode encodings.
package io_bank_pkg;

    localparam int IO_MODE_W = 2;

    typedef enum logic [IO_MODE_W-1:0] {
        IO_MODE_DISABLED = 2'b00,
        IO_MODE_INPUT    = 2'b01,
        IO_MODE_OUTPUT   = 2'b10,
        IO_MODE_OUT_INV  = 2'b11
    } io_mode_e;

endpackage

// File: rtl/logical_tile_io_bank_cfg_if.sv
// Serial configuration chain bundle: shift/load controls in, tail and status out.
interface logical_tile_io_bank_cfg_if;

    logic ccff_head;
    logic ccff_shift_en;
    logic ccff_load;
    logic ccff_tail;
    logic cfg_valid;
    logic cfg_err;

    modport master (
        output ccff_head, ccff_shift_en, ccff_load,
        input  ccff_tail, cfg_valid, cfg_err
    );

    modport slave (
        input  ccff_head, ccff_shift_en, ccff_load,
        output ccff_tail, cfg_valid, cfg_err
    );

endinterface

// File: rtl/logical_tile_io_bank_cfg_chan.sv
// One pad channel: mode decode plus isolation override, purely combinational.
module io_bank_chan
    import io_bank_pkg::*;
(
    input  io_mode_e mode,
    input  logic     isol_n,
    input  logic     pad_in,
    input  logic     outpad,
    output logic     dir,
    output logic     pad_out,
    output logic     inpad
);

    always_comb begin
        dir     = 1'b1;
        pad_out = 1'b0;
        inpad   = 1'b0;
        if (isol_n) begin
            case (mode)
                IO_MODE_INPUT:   inpad = pad_in;
                IO_MODE_OUTPUT:  begin dir = 1'b0; pad_out = outpad;  end
                IO_MODE_OUT_INV: begin dir = 1'b0; pad_out = ~outpad; end
                default:         ;
            endcase
        end
    end

endmodule

// File: rtl/logical_tile_io_bank_cfg.sv
// IO bank tile: shadowed config chain with length-checked commit driving NUM_IO pad channels.
module logical_tile_io_bank_cfg
    import io_bank_pkg::*;
#(
    parameter int NUM_IO = 4
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              IO_ISOL_N,
    input  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
    output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
    output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
    input  logic [NUM_IO-1:0] io_outpad,
    output logic [NUM_IO-1:0] io_inpad,
    logical_tile_io_bank_cfg_if.slave ccff
);

    localparam int CHAIN_LEN = 2 * NUM_IO;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

    logic [CHAIN_LEN-1:0] chain_q, chain_d;
    logic [CHAIN_LEN-1:0] active_q, active_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;

    // Load takes priority and sees the pre-shift chain; a coincident shift is dropped.
    always_comb begin
        chain_d  = chain_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        err_d    = err_q;
        if (ccff.ccff_load) begin
            cnt_d = '0;
            if (cnt_q == CNT_FULL) begin
                active_d = chain_q;
                valid_d  = 1'b1;
                err_d    = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else if (ccff.ccff_shift_en) begin
            chain_d = {chain_q[CHAIN_LEN-2:0], ccff.ccff_head};
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            chain_q  <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            chain_q  <= chain_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign ccff.ccff_tail = chain_q[CHAIN_LEN-1];
    assign ccff.cfg_valid = valid_q;
    assign ccff.cfg_err   = err_q;

    for (genvar i = 0; i < NUM_IO; i++) begin : g_chan
        io_bank_chan u_chan (
            .mode    (io_mode_e'(active_q[IO_MODE_W*i +: IO_MODE_W])),
            .isol_n  (IO_ISOL_N),
            .pad_in  (gfpga_pad_EMBEDDED_IO_HD_SOC_IN[i]),
            .outpad  (io_outpad[i]),
            .dir     (gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[i]),
            .pad_out (gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[i]),
            .inpad   (io_inpad[i])
        );
    end

endmodule

// File: tb/tb_logical_tile_io_bank_cfg.sv
// Directed self-checking bench for the IO bank tile with NUM_IO=4.
module tb_logical_tile_io_bank_cfg;

    logic       prog_clk = 1'b0;
    logic       pReset;
    logic       IO_ISOL_N;
    logic [3:0] pad_in;
    logic [3:0] pad_out;
    logic [3:0] pad_dir;
    logic [3:0] io_outpad;
    logic [3:0] io_inpad;

    int passed = 0;
    int total  = 0;

    logical_tile_io_bank_cfg_if ccff ();

    logical_tile_io_bank_cfg #(.NUM_IO(4)) dut (
        .prog_clk                         (prog_clk),
        .pReset                           (pReset),
        .IO_ISOL_N                        (IO_ISOL_N),
        .gfpga_pad_EMBEDDED_IO_HD_SOC_IN  (pad_in),
        .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT (pad_out),
        .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR (pad_dir),
        .io_outpad                        (io_outpad),
        .io_inpad                         (io_inpad),
        .ccff                             (ccff.slave)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic shift_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge prog_clk);
            ccff.ccff_head     = v[i];
            ccff.ccff_shift_en = 1'b1;
        end
        @(negedge prog_clk);
        ccff.ccff_shift_en = 1'b0;
        ccff.ccff_head     = 1'b0;
    endtask

    task automatic do_load();
        @(negedge prog_clk);
        ccff.ccff_load = 1'b1;
        @(negedge prog_clk);
        ccff.ccff_load = 1'b0;
    endtask

    task automatic check_pads(input string name, input logic [3:0] e_out,
                              input logic [3:0] e_dir, input logic [3:0] e_in);
        total++;
        if ({pad_out, pad_dir, io_inpad} !== {e_out, e_dir, e_in})
            $display("FAIL %s: out/dir/inpad=%b/%b/%b expected %b/%b/%b",
                     name, pad_out, pad_dir, io_inpad, e_out, e_dir, e_in);
        else passed++;
    endtask

    task automatic check_flags(input string name, input logic e_valid, input logic e_err);
        total++;
        if ({ccff.cfg_valid, ccff.cfg_err} !== {e_valid, e_err})
            $display("FAIL %s: valid/err=%b/%b expected %b/%b",
                     name, ccff.cfg_valid, ccff.cfg_err, e_valid, e_err);
        else passed++;
    endtask

    task automatic test_reset();
        pReset = 1'b1;
        #12;
        check_pads("reset_pads", 4'h0, 4'hF, 4'h0);
        check_flags("reset_flags", 1'b0, 1'b0);
        @(negedge prog_clk);
        pReset = 1'b0;
        shift_bits(16'b10011100, 8);
        do_load();
        check_flags("pre_reset_flags", 1'b1, 1'b0);
        // Reset asynchronously, away from any clock edge, mid-shift.
        @(negedge prog_clk);
        ccff.ccff_head     = 1'b1;
        ccff.ccff_shift_en = 1'b1;
        @(posedge prog_clk);
        #2;
        pReset = 1'b1;
        #1;
        check_pads("async_reset_pads", 4'h0, 4'hF, 4'h0);
        check_flags("async_reset_flags", 1'b0, 1'b0);
        total++;
        if (ccff.ccff_tail !== 1'b0) $display("FAIL async_reset_tail: tail=%b expected 0", ccff.ccff_tail);
        else passed++;
        ccff.ccff_shift_en = 1'b0;
        ccff.ccff_head     = 1'b0;
        @(negedge prog_clk);
        pReset = 1'b0;
    endtask

    task automatic test_good_commit();
        shift_bits(16'b10011100, 8);
        check_flags("pre_commit_flags", 1'b0, 1'b0);
        check_pads("pre_commit_pads", 4'h0, 4'hF, 4'h0);
        do_load();
        check_flags("good_commit_flags", 1'b1, 1'b0);
        check_pads("good_commit_pads", 4'b1000, 4'b0101, 4'b0100);
        io_outpad = 4'h0;
        pad_in    = 4'b1011;
        #1;
        check_pads("good_commit_pads2", 4'b0010, 4'b0101, 4'b0000);
        io_outpad = 4'hF;
        pad_in    = 4'hF;
    endtask

    task automatic test_bad_commit();
        shift_bits(16'b0110_0011, 7);
        do_load();
        check_flags("short_commit_flags", 1'b1, 1'b1);
        check_pads("short_commit_pads", 4'b1000, 4'b0101, 4'b0100);
        shift_bits(16'b1_0110_0011, 9);
        do_load();
        check_flags("overflow_commit_flags", 1'b1, 1'b1);
        check_pads("overflow_commit_pads", 4'b1000, 4'b0101, 4'b0100);
    endtask

    task automatic test_shift_load_same_cycle();
        shift_bits(16'b01100011, 8);
        @(negedge prog_clk);
        ccff.ccff_head     = 1'b1;
        ccff.ccff_shift_en = 1'b1;
        ccff.ccff_load     = 1'b1;
        @(negedge prog_clk);
        ccff.ccff_shift_en = 1'b0;
        ccff.ccff_load     = 1'b0;
        ccff.ccff_head     = 1'b0;
        check_flags("combo_flags", 1'b1, 1'b0);
        check_pads("combo_pads", 4'b0100, 4'b1010, 4'b1000);
        total++;
        if (ccff.ccff_tail !== 1'b0) $display("FAIL combo_tail: tail=%b expected 0", ccff.ccff_tail);
        else passed++;
        // Counter must restart from zero: exactly 8 more shifts commit cleanly.
        shift_bits(16'b10011100, 8);
        do_load();
        check_flags("combo_recommit_flags", 1'b1, 1'b0);
        check_pads("combo_recommit_pads", 4'b1000, 4'b0101, 4'b0100);
    endtask

    task automatic test_isolation();
        @(negedge prog_clk);
        IO_ISOL_N = 1'b0;
        #1;
        check_pads("isolated_pads", 4'h0, 4'hF, 4'h0);
        check_flags("isolated_flags", 1'b1, 1'b0);
        @(negedge prog_clk);
        IO_ISOL_N = 1'b1;
        #1;
        check_pads("released_pads", 4'b1000, 4'b0101, 4'b0100);
    endtask

    task automatic test_chaining();
        logic [15:0] bits;
        bits = 16'b1011_0010_1110_0101;
        for (int i = 0; i < 16; i++) begin
            @(negedge prog_clk);
            if (i >= 8) begin
                total++;
                if (ccff.ccff_tail !== bits[i-8])
                    $display("FAIL chain_tail_%0d: tail=%b expected %b", i, ccff.ccff_tail, bits[i-8]);
                else passed++;
            end
            ccff.ccff_head     = bits[i];
            ccff.ccff_shift_en = 1'b1;
        end
        @(negedge prog_clk);
        ccff.ccff_shift_en = 1'b0;
        total++;
        if (ccff.ccff_tail !== bits[8])
            $display("FAIL chain_tail_16: tail=%b expected %b", ccff.ccff_tail, bits[8]);
        else passed++;
        check_pads("chain_no_commit_pads", 4'b1000, 4'b0101, 4'b0100);
    endtask

    initial begin
        IO_ISOL_N          = 1'b1;
        pad_in             = 4'hF;
        io_outpad          = 4'hF;
        ccff.ccff_head     = 1'b0;
        ccff.ccff_shift_en = 1'b0;
        ccff.ccff_load     = 1'b0;
        test_reset();
        test_good_commit();
        test_bad_commit();
        test_shift_load_same_cycle();
        test_isolation();
        test_chaining();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
